// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: DMA request priority resolver and HRQ/HLDA/DACK handshake.
// Ports:
//   CLK, RESET (sync, active-high).
//   DREQ, mask, sw_req: channel requests, the mask register and software requests.
//   HLDA, xfer_done: CPU hold acknowledge and the end-of-service pulse.
//   ctrl_disable, rot_pri_en, dreq_sense_low, dack_sense_high: command-register controls.
//   HRQ, DACK: CPU hold request and per-channel acknowledge.
//   active_ch, ch_valid: the granted channel index and its valid flag.
//   req_done: one-hot pulse on normal completion of a service.
// Optional macro DMA_ARB_DREQ_SYNC_EN adds a two-flop synchronizer on each DREQ bit.
module dma_priority_arbiter #(
   parameter int NUM_CH = 4,
   localparam int CW = $clog2(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic              HLDA,
   input  logic [NUM_CH-1:0] mask,
   input  logic [NUM_CH-1:0] sw_req,
   input  logic              ctrl_disable,
   input  logic              rot_pri_en,
   input  logic              dreq_sense_low,
   input  logic              dack_sense_high,
   input  logic              xfer_done,
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic [CW-1:0]     active_ch,
   output logic              ch_valid,
   output logic [NUM_CH-1:0] req_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      GRANT = 2'd2
   } state_t;

   state_t            state;
   logic [NUM_CH-1:0] dreq_q;
   logic [NUM_CH-1:0] eff_req;
   logic [NUM_CH-1:0] dack_int;
   logic [CW-1:0]     prio_top;
   logic [CW-1:0]     base;
   logic [CW-1:0]     idx;
   logic [CW-1:0]     win;
   logic              found;

`ifdef DMA_ARB_DREQ_SYNC_EN
   logic [NUM_CH-1:0] dreq_s1;
   logic [NUM_CH-1:0] dreq_s2;

   // Flops reset to the inactive pin level so no request is seen out of reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         dreq_s1 <= {NUM_CH{dreq_sense_low}};
         dreq_s2 <= {NUM_CH{dreq_sense_low}};
      end else begin
         dreq_s1 <= DREQ;
         dreq_s2 <= dreq_s1;
      end
   end

   assign dreq_q = dreq_s2;
`else
   assign dreq_q = DREQ;
`endif

   assign eff_req = ((dreq_q ^ {NUM_CH{dreq_sense_low}}) & ~mask) | sw_req;

   // Circular search starting at base; CW-bit addition wraps modulo NUM_CH
   always_comb begin
      base  = rot_pri_en ? prio_top : '0;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = base + CW'(i);
         if (!found && eff_req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         HRQ       <= 1'b0;
         dack_int  <= '0;
         active_ch <= '0;
         ch_valid  <= 1'b0;
         req_done  <= '0;
         prio_top  <= '0;
      end else begin
         req_done <= '0;
         case (state)
            IDLE: begin
               if (|eff_req && !ctrl_disable) begin
                  state <= REQ;
                  HRQ   <= 1'b1;
               end
            end
            REQ: begin
               if (ctrl_disable || !(|eff_req)) begin
                  state <= IDLE;
                  HRQ   <= 1'b0;
               end else if (HLDA) begin
                  state     <= GRANT;
                  active_ch <= win;
                  dack_int  <= NUM_CH'(1) << win;
                  ch_valid  <= 1'b1;
               end
            end
            GRANT: begin
               // xfer_done wins over a simultaneous HLDA drop
               if (xfer_done) begin
                  state    <= IDLE;
                  HRQ      <= 1'b0;
                  dack_int <= '0;
                  ch_valid <= 1'b0;
                  req_done <= dack_int;
                  if (rot_pri_en)
                     prio_top <= active_ch + CW'(1);
               end else if (!HLDA) begin
                  state    <= IDLE;
                  HRQ      <= 1'b0;
                  dack_int <= '0;
                  ch_valid <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               HRQ      <= 1'b0;
               dack_int <= '0;
               ch_valid <= 1'b0;
            end
         endcase
      end
   end

   assign DACK = dack_int ^ {NUM_CH{~dack_sense_high}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed vector bench for dma_priority_arbiter.
// Vectors are driven on negedge and outputs checked 1 time unit after posedge.
module tb_dma_priority_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] DREQ;
   logic       HLDA;
   logic [3:0] mask;
   logic [3:0] sw_req;
   logic       ctrl_disable;
   logic       rot_pri_en;
   logic       dreq_sense_low;
   logic       dack_sense_high;
   logic       xfer_done;
   logic       HRQ;
   logic [3:0] DACK;
   logic [1:0] active_ch;
   logic       ch_valid;
   logic [3:0] req_done;

   int checks = 0;
   int errors = 0;
   int vn = 0;

   always #5 CLK = ~CLK;

   dma_priority_arbiter #(.NUM_CH(4)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .DREQ(DREQ),
      .HLDA(HLDA),
      .mask(mask),
      .sw_req(sw_req),
      .ctrl_disable(ctrl_disable),
      .rot_pri_en(rot_pri_en),
      .dreq_sense_low(dreq_sense_low),
      .dack_sense_high(dack_sense_high),
      .xfer_done(xfer_done),
      .HRQ(HRQ),
      .DACK(DACK),
      .active_ch(active_ch),
      .ch_valid(ch_valid),
      .req_done(req_done)
   );

   typedef struct {
      logic       rst;
      logic [3:0] dreq;
      logic       hlda;
      logic [3:0] mask;
      logic [3:0] sw;
      logic       xd;
      logic       rot;
      logic       dsl;
      logic       dsh;
      logic       hrq;
      logic [3:0] dack;
      logic [1:0] ach;
      logic       val;
      logic [3:0] done;
   } vec_t;

   function automatic vec_t v(
      input logic rst, input logic [3:0] dreq, input logic hlda,
      input logic [3:0] mk, input logic [3:0] sw, input logic xd,
      input logic rot, input logic dsl, input logic dsh,
      input logic hrq, input logic [3:0] dack, input logic [1:0] ach,
      input logic val, input logic [3:0] done);
      vec_t t;
      t.rst = rst; t.dreq = dreq; t.hlda = hlda; t.mask = mk;
      t.sw = sw; t.xd = xd; t.rot = rot; t.dsl = dsl; t.dsh = dsh;
      t.hrq = hrq; t.dack = dack; t.ach = ach; t.val = val;
      t.done = done;
      return t;
   endfunction

   // Common case: fixed priority, high-sense, no mask, no software request
   function automatic vec_t vv(
      input logic [3:0] dreq, input logic hlda, input logic xd,
      input logic hrq, input logic [3:0] dack, input logic [1:0] ach,
      input logic val, input logic [3:0] done);
      return v(1'b0, dreq, hlda, 4'b0, 4'b0, xd, 1'b0, 1'b0, 1'b1,
               hrq, dack, ach, val, done);
   endfunction

   task automatic chk(input string nm, input logic [3:0] got,
                      input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL vec%0d %s got %b exp %b", vn, nm, got, exp);
      end
   endtask

   task automatic step(input vec_t t);
      @(negedge CLK);
      RESET = t.rst; DREQ = t.dreq; HLDA = t.hlda; mask = t.mask;
      sw_req = t.sw; xfer_done = t.xd; rot_pri_en = t.rot;
      dreq_sense_low = t.dsl; dack_sense_high = t.dsh;
      @(posedge CLK);
      #1;
      chk("HRQ", {3'b0, HRQ}, {3'b0, t.hrq});
      chk("DACK", DACK, t.dack);
      chk("ch_valid", {3'b0, ch_valid}, {3'b0, t.val});
      chk("req_done", req_done, t.done);
      if (t.val)
         chk("active_ch", {2'b0, active_ch}, {2'b0, t.ach});
      vn++;
   endtask

   vec_t tbl[$];
   vec_t rst_v;

   initial begin
      RESET = 1'b1; DREQ = '0; HLDA = 1'b0; mask = '0; sw_req = '0;
      ctrl_disable = 1'b0; rot_pri_en = 1'b0; dreq_sense_low = 1'b0;
      dack_sense_high = 1'b1; xfer_done = 1'b0;
      rst_v = v(1'b1, 4'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b0, 4'b0, 2'd0, 1'b0, 4'b0);

`ifdef DMA_ARB_DREQ_SYNC_EN
      step(rst_v);
      step(vv(4'b0001, 0, 0, 0, 4'b0, 0, 0, 4'b0));
      step(vv(4'b0001, 0, 0, 0, 4'b0, 0, 0, 4'b0));
      step(vv(4'b0001, 0, 0, 1, 4'b0, 0, 0, 4'b0));
      step(rst_v);
      step(vv(4'b0001, 0, 0, 0, 4'b0, 0, 0, 4'b0));
      step(vv(4'b0000, 0, 0, 0, 4'b0, 0, 0, 4'b0));
      step(vv(4'b0000, 0, 0, 1, 4'b0, 0, 0, 4'b0));
      step(vv(4'b0000, 0, 0, 0, 4'b0, 0, 0, 4'b0));
      step(vv(4'b0000, 0, 0, 0, 4'b0, 0, 0, 4'b0));
`else
      tbl.push_back(rst_v);
      // Fixed priority: ch1 then ch3
      tbl.push_back(vv(4'b1010, 0, 0, 1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b1010, 0, 0, 1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b1010, 1, 0, 1, 4'b0010, 1, 1, 4'b0000));
      tbl.push_back(vv(4'b1010, 1, 0, 1, 4'b0010, 1, 1, 4'b0000));
      tbl.push_back(vv(4'b1010, 1, 1, 0, 4'b0000, 0, 0, 4'b0010));
      tbl.push_back(vv(4'b1000, 1, 0, 1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b1000, 1, 0, 1, 4'b1000, 3, 1, 4'b0000));
      tbl.push_back(vv(4'b1000, 1, 1, 0, 4'b0000, 0, 0, 4'b1000));
      tbl.push_back(vv(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));
      // Withdrawal in REQ
      tbl.push_back(vv(4'b0100, 0, 0, 1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));
      // Abort by HLDA drop, then reset mid-GRANT
      tbl.push_back(vv(4'b0100, 0, 0, 1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b0100, 1, 0, 1, 4'b0100, 2, 1, 4'b0000));
      tbl.push_back(vv(4'b0100, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b0100, 0, 0, 1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b0100, 1, 0, 1, 4'b0100, 2, 1, 4'b0000));
      tbl.push_back(v(1, 4'b0100, 1, 4'b0, 4'b0, 0, 0, 0, 1,
                      0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));
      // Mask, software request, DACK low sense
      tbl.push_back(v(0, 4'b0001, 0, 4'b0001, 4'b1000, 0, 0, 0, 1,
                      1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 1, 4'b0001, 4'b1000, 0, 0, 0, 1,
                      1, 4'b1000, 3, 1, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 1, 4'b0001, 4'b1000, 0, 0, 0, 0,
                      1, 4'b0111, 3, 1, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 1, 4'b0001, 4'b1000, 1, 0, 0, 0,
                      0, 4'b1111, 0, 0, 4'b1000));
      // DREQ low sense: ch0 requests but is masked, then unmasked
      tbl.push_back(v(0, 4'b1110, 0, 4'b0001, 4'b0000, 0, 0, 1, 1,
                      0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(v(0, 4'b1110, 0, 4'b0000, 4'b0000, 0, 0, 1, 1,
                      1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(v(0, 4'b1110, 1, 4'b0000, 4'b0000, 0, 0, 1, 1,
                      1, 4'b0001, 0, 1, 4'b0000));
      tbl.push_back(v(0, 4'b1110, 1, 4'b0000, 4'b0000, 1, 0, 1, 1,
                      0, 4'b0000, 0, 0, 4'b0001));
      tbl.push_back(vv(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));
      // Mask set during GRANT keeps the grant
      tbl.push_back(vv(4'b0010, 0, 0, 1, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(vv(4'b0010, 1, 0, 1, 4'b0010, 1, 1, 4'b0000));
      tbl.push_back(v(0, 4'b0010, 1, 4'b0010, 4'b0000, 0, 0, 0, 1,
                      1, 4'b0010, 1, 1, 4'b0000));
      tbl.push_back(v(0, 4'b0010, 1, 4'b0010, 4'b0000, 1, 0, 0, 1,
                      0, 4'b0000, 0, 0, 4'b0010));
      tbl.push_back(vv(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));

      foreach (tbl[i])
         step(tbl[i]);

      // Controller disable blocks a request in IDLE
      ctrl_disable = 1'b1;
      step(vv(4'b0001, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));
      step(vv(4'b0001, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));
      ctrl_disable = 1'b0;
      step(vv(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000));

      // Rotating priority: order 0,1,2,3,0 with all channels requesting
      step(rst_v);
      begin
         int order [5] = '{0, 1, 2, 3, 0};
         foreach (order[k]) begin
            logic [3:0] oh;
            oh = 4'b0001 << order[k];
            step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 1, 0, 1,
                   1, 4'b0000, 0, 0, 4'b0000));
            step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 1, 0, 1,
                   1, oh, 2'(order[k]), 1, 4'b0000));
            step(v(0, 4'hF, 1, 4'b0, 4'b0, 1, 1, 0, 1,
                   0, 4'b0000, 0, 0, oh));
         end
      end
      // Abort of ch1 leaves prio_top at 1
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0000, 0, 0, 4'b0));
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0010, 1, 1, 4'b0));
      step(v(0, 4'hF, 0, 4'b0, 4'b0, 0, 1, 0, 1, 0, 4'b0000, 0, 0, 4'b0));
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0000, 0, 0, 4'b0));
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0010, 1, 1, 4'b0));
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 1, 1, 0, 1, 0, 4'b0000, 0, 0, 4'b0010));
      // Fixed mode ignores prio_top=2; switching back resumes at ch2
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0));
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 0, 0, 1, 1, 4'b0001, 0, 1, 4'b0));
      step(v(0, 4'hF, 0, 4'b0, 4'b0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 4'b0));
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0000, 0, 0, 4'b0));
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0100, 2, 1, 4'b0));
      step(v(0, 4'hF, 1, 4'b0, 4'b0, 1, 1, 0, 1, 0, 4'b0000, 0, 0, 4'b0100));
      // 3 -> 0 wrap of prio_top after servicing ch3
      step(v(0, 4'b1001, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0000, 0, 0, 4'b0));
      step(v(0, 4'b1001, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b1000, 3, 1, 4'b0));
      step(v(0, 4'b1001, 1, 4'b0, 4'b0, 1, 1, 0, 1, 0, 4'b0000, 0, 0, 4'b1000));
      step(v(0, 4'b1001, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0000, 0, 0, 4'b0));
      step(v(0, 4'b1001, 1, 4'b0, 4'b0, 0, 1, 0, 1, 1, 4'b0001, 0, 1, 4'b0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
